smi_stream_arbiter: RTL and testbench

Parametrised SMI streaming controller: round-robin drains up to four sample FIFOs and serialises each DATA_W-bit word into bytes on the 8-bit SMI read bus, one byte per host read strobe. Sits between the per-radio RX FIFOs and the SMI pins, alongside the IOC register bus. Adds channel-enable masking, burst-limited fair arbitration and a live status register.

---
 rtl/smi_pkg.sv | 19 +
 rtl/smi_rr_arbiter.sv | 30 +++
 rtl/smi_stream_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_smi_stream_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smi_pkg.sv
// Shared constants and FSM encoding for the SMI streaming controller.
package smi_pkg;

    localparam int         MAX_CH             = 4;
    localparam logic [7:0] MODULE_VERSION_DEF = 8'h02;

    localparam logic [4:0] IOC_VERSION = 5'd0;
    localparam logic [4:0] IOC_STATUS  = 5'd1;
    localparam logic [4:0] IOC_MASK    = 5'd2;
    localparam logic [4:0] IOC_STATE   = 5'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULL  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHIFT = 2'd3
    } smi_state_e;

endpackage

// File: rtl/smi_rr_arbiter.sv
// Combinational round-robin pick: first eligible channel after last_ch, wrapping.
module smi_rr_arbiter
    import smi_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0] i_eligible,
    input  logic [1:0]        i_last_ch,
    output logic [1:0]        o_grant,
    output logic              o_valid
);

    logic [MAX_CH-1:0] elig_pad;
    logic [1:0]        idx;

    always_comb begin
        elig_pad = MAX_CH'(i_eligible);
        o_grant  = 2'd0;
        o_valid  = 1'b0;
        idx      = 2'd0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = 2'((int'(i_last_ch) + i) % NUM_CH);
            if (!o_valid && elig_pad[idx]) begin
                o_grant = idx;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smi_stream_arbiter.sv
// Round-robin drains sample FIFOs and serialises each word LSB byte first onto
// the SMI read bus, one byte per host strobe; small IOC register file alongside.
module smi_stream_arbiter
    import smi_pkg::*;
#(
    parameter int         NUM_CH         = 2,
    parameter int         DATA_W         = 32,
    parameter int         BURST_WORDS    = 16,
    parameter logic [7:0] MODULE_VERSION = MODULE_VERSION_DEF
) (
    input  logic                     i_sys_clk,
    input  logic                     i_rst,
    input  logic [4:0]               i_ioc,
    input  logic [7:0]               i_data_in,
    output logic [7:0]               o_data_out,
    input  logic                     i_cs,
    input  logic                     i_fetch_cmd,
    input  logic                     i_load_cmd,
    output logic [NUM_CH-1:0]        o_fifo_pull,
    input  logic [NUM_CH*DATA_W-1:0] i_fifo_pulled_data,
    input  logic [NUM_CH-1:0]        i_fifo_empty,
    input  logic [NUM_CH-1:0]        i_fifo_full,
    input  logic                     i_smi_soe_se,
    output logic [7:0]               o_smi_data_out,
    output logic                     o_smi_read_req,
    output logic [1:0]               o_active_ch
);

    localparam int              NBYTES    = DATA_W / 8;
    localparam int              BI_W      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(NBYTES - 1);

    smi_state_e        state_q, state_d;
    logic [1:0]        cur_ch_q, cur_ch_d;
    logic [1:0]        last_ch_q, last_ch_d;
    logic [7:0]        word_cnt_q, word_cnt_d;
    logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;

    logic [NUM_CH-1:0] eligible;
    logic [MAX_CH-1:0] elig_pad, pull_pad;
    logic              cur_elig, strobe;
    logic [1:0]        grant;
    logic              grant_valid;
    logic [DATA_W-1:0] pulled_word;
    logic [7:0]        status, rd_mux;
    logic              unused_data;

    assign unused_data = ^i_data_in;

    assign eligible = mask_q & ~i_fifo_empty;
    assign elig_pad = MAX_CH'(eligible);
    assign cur_elig = elig_pad[cur_ch_q];
    assign strobe   = sync2_q & ~edge_q;

    smi_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_eligible (eligible),
        .i_last_ch  (last_ch_q),
        .o_grant    (grant),
        .o_valid    (grant_valid)
    );

    always_comb begin
        pulled_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch_q == 2'(k)) pulled_word = i_fifo_pulled_data[k*DATA_W +: DATA_W];
        end
    end

    // Host strobe crosses in through two flops; the third flop gives the rising edge.
    always_comb begin
        sync1_d = i_smi_soe_se;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
    end

    always_comb begin
        state_d    = state_q;
        cur_ch_d   = cur_ch_q;
        last_ch_d  = last_ch_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    cur_ch_d   = grant;
                    word_cnt_d = 8'd0;
                    state_d    = ST_PULL;
                end
            end
            ST_PULL: state_d = ST_LOAD;
            ST_LOAD: begin
                shift_d    = pulled_word;
                byte_idx_d = '0;
                state_d    = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (strobe) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        word_cnt_d = word_cnt_q + 8'd1;
                        // Continuation re-checks eligibility so a mask cleared mid-word ends the grant.
                        if ((9'(word_cnt_q) + 9'd1 < 9'(BURST_WORDS)) && cur_elig) begin
                            state_d = ST_PULL;
                        end else begin
                            last_ch_d = cur_ch_q;
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        shift_d    = shift_q >> 8;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        status = 8'h00;
        for (int k = 0; k < NUM_CH; k++) begin
            status[2*k]   = i_fifo_empty[k];
            status[2*k+1] = i_fifo_full[k];
        end
        case (i_ioc)
            IOC_VERSION: rd_mux = MODULE_VERSION;
            IOC_STATUS:  rd_mux = status;
            IOC_MASK:    rd_mux = 8'(mask_q);
            IOC_STATE:   rd_mux = {state_q, 4'b0000, cur_ch_q};
            default:     rd_mux = 8'h00;
        endcase

        data_out_d = data_out_q;
        if (!i_cs)            data_out_d = 8'h00;
        else if (i_fetch_cmd) data_out_d = rd_mux;

        mask_d = mask_q;
        if (i_cs && i_load_cmd && i_ioc == IOC_MASK) mask_d = i_data_in[NUM_CH-1:0];
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cur_ch_q   <= 2'd0;
            last_ch_q  <= 2'(NUM_CH - 1);
            word_cnt_q <= 8'd0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            mask_q     <= '1;
            data_out_q <= 8'h00;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_ch_q   <= cur_ch_d;
            last_ch_q  <= last_ch_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            mask_q     <= mask_d;
            data_out_q <= data_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            edge_q     <= edge_d;
        end
    end

    always_comb begin
        pull_pad = '0;
        if (state_q == ST_PULL) pull_pad = MAX_CH'(1) << cur_ch_q;
    end

    assign o_fifo_pull    = pull_pad[NUM_CH-1:0];
    assign o_smi_read_req = (state_q == ST_SHIFT);
    assign o_smi_data_out = o_smi_read_req ? shift_q[7:0] : 8'h00;
    assign o_active_ch    = cur_ch_q;
    assign o_data_out     = data_out_q;

endmodule

// File: tb/tb_smi_stream_arbiter.sv
// Bench for smi_stream_arbiter: FIFO models, a host strobe driver, and a
// queue-level round-robin/burst reference model of the expected byte stream.
module tb_smi_stream_arbiter;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 32;
    localparam int BURST  = 16;
    localparam int NB     = DATA_W / 8;
    localparam int DEPTH  = 20;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [4:0]               ioc;
    logic [7:0]               din;
    logic [7:0]               dout;
    logic                     cs, fetch, load;
    logic [NUM_CH-1:0]        pull;
    logic [NUM_CH*DATA_W-1:0] pulled = '0;
    logic [NUM_CH-1:0]        empty, full;
    logic                     soe;
    logic [7:0]               smi_data;
    logic                     read_req;
    logic [1:0]               active_ch;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    smi_stream_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BURST_WORDS(BURST), .MODULE_VERSION(8'h02)) dut (
        .i_sys_clk          (clk),
        .i_rst              (rst),
        .i_ioc              (ioc),
        .i_data_in          (din),
        .o_data_out         (dout),
        .i_cs               (cs),
        .i_fetch_cmd        (fetch),
        .i_load_cmd         (load),
        .o_fifo_pull        (pull),
        .i_fifo_pulled_data (pulled),
        .i_fifo_empty       (empty),
        .i_fifo_full        (full),
        .i_smi_soe_se       (soe),
        .o_smi_data_out     (smi_data),
        .o_smi_read_req     (read_req),
        .o_active_ch        (active_ch)
    );

    // FIFO models: the initial block only advances wr_ptr, the monitor only rd_ptr.
    logic [DATA_W-1:0] mem [NUM_CH][256];
    int wr_ptr   [NUM_CH] = '{default: 0};
    int rd_ptr   [NUM_CH] = '{default: 0};
    int pull_cnt [NUM_CH] = '{default: 0};
    int underflow_cnt = 0;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            empty[k] = (wr_ptr[k] == rd_ptr[k]);
            full[k]  = (wr_ptr[k] - rd_ptr[k] >= DEPTH);
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (pull[k]) begin
                pull_cnt[k] <= pull_cnt[k] + 1;
                if (rd_ptr[k] == wr_ptr[k]) underflow_cnt <= underflow_cnt + 1;
                else begin
                    pulled[k*DATA_W +: DATA_W] <= mem[k][rd_ptr[k] % 256];
                    rd_ptr[k] <= rd_ptr[k] + 1;
                end
            end
        end
    end

    // Reference model: per-channel word queues, mask, last grant; emits {ch, byte}.
    logic [DATA_W-1:0] mq [NUM_CH][$];
    logic [NUM_CH-1:0] mask_m = '1;
    int                last_m = NUM_CH - 1;
    logic [9:0]        exp_q [$];
    logic [9:0]        obs_q [$];

    function automatic void push_word(input int ch, input logic [DATA_W-1:0] w);
        for (int b = 0; b < NB; b++) exp_q.push_back({2'(ch), w[8*b +: 8]});
    endfunction

    function automatic void model_run();
        int ch;
        int c;
        while (1) begin
            ch = -1;
            for (int i = 1; i <= NUM_CH; i++) begin
                c = (last_m + i) % NUM_CH;
                if (ch < 0 && mask_m[c] && mq[c].size() > 0) ch = c;
            end
            if (ch < 0) break;
            for (int n = 0; n < BURST && mq[ch].size() > 0; n++) push_word(ch, mq[ch].pop_front());
            last_m = ch;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_m = NUM_CH - 1;
    endtask

    task automatic load_word(input int ch, input logic [DATA_W-1:0] w);
        mem[ch][wr_ptr[ch] % 256] = w;
        wr_ptr[ch] = wr_ptr[ch] + 1;
        mq[ch].push_back(w);
    endtask

    task automatic reg_read(input logic [4:0] a, output logic [7:0] v);
        ioc = a; cs = 1'b1; fetch = 1'b1;
        tick();
        v = dout;
        cs = 1'b0; fetch = 1'b0;
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [7:0] v);
        ioc = a; din = v; cs = 1'b1; load = 1'b1;
        tick();
        cs = 1'b0; load = 1'b0;
    endtask

    // Pin high 2 cycles, low 3: spacing of 5 sys clocks between rising edges.
    task automatic strobe();
        soe = 1'b1;
        tick(); tick();
        soe = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (read_req) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // Host side: read up to max_bytes bytes, stopping when read_req stays low.
    task automatic collect(input int max_bytes);
        bit ok;
        for (int n = 0; n < max_bytes; n++) begin
            wait_req(ok);
            if (!ok) return;
            obs_q.push_back({active_ch, smi_data});
            strobe();
        end
    endtask

    task automatic test_reset();
        logic [7:0] v;
        int p1;
        rst = 1'b1; soe = 1'b0; cs = 1'b0; fetch = 1'b0; load = 1'b0; ioc = '0; din = '0;
        tick(); tick();
        checks++;
        if ({dout, pull, smi_data, read_req, active_ch} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got dout=%h pull=%b smi=%h req=%b ch=%0d, all zero required",
                     dout, pull, smi_data, read_req, active_ch);
        end
        rst = 1'b0;
        last_m = NUM_CH - 1;
        reg_read(5'd0, v);
        checks++;
        if (v !== 8'h02) begin failures++; $display("FAIL ioc_version: got %h exp 02", v); end
        reg_read(5'd2, v);
        checks++;
        if (v !== 8'h03) begin failures++; $display("FAIL ioc_mask_reset: got %h exp 03", v); end
        reg_read(5'd3, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL ioc_state_idle: got %h exp 00", v); end
        reg_write(5'd2, 8'h00);
        p1 = pull_cnt[1];
        for (int i = 0; i < DEPTH; i++) load_word(1, $urandom);
        tick(); tick(); tick();
        reg_read(5'd1, v);
        checks++;
        if (v !== 8'b0000_1001) begin failures++; $display("FAIL ioc_status: got %b exp 00001001", v); end
        reg_read(5'd7, v);
        checks++;
        if (v !== 8'h00) begin failures++; $display("FAIL ioc_unlisted: got %h exp 00", v); end
        checks++;
        if (pull_cnt[1] - p1 !== 0) begin failures++; $display("FAIL masked_no_pull: got %0d pulls exp 0", pull_cnt[1] - p1); end
        reg_read(5'd0, v);
        tick();
        checks++;
        if (dout !== 8'h00) begin failures++; $display("FAIL dout_cs_low: got %h exp 00", dout); end
        wr_ptr[1] = rd_ptr[1];
        mq[1].delete();
        reg_write(5'd2, 8'h03);
        mask_m = 2'b11;
    endtask

    task automatic test_single_word();
        logic [7:0] v;
        int p0, p1;
        p0 = pull_cnt[0]; p1 = pull_cnt[1];
        obs_q.delete(); exp_q.delete();
        load_word(0, 32'hA1B2C3D4);
        tick(); tick();
        checks++;
        if (read_req !== 1'b0) begin failures++; $display("FAIL latency_early: read_req=%b at N+2, exp 0", read_req); end
        tick();
        checks++;
        if ({read_req, smi_data} !== {1'b1, 8'hD4}) begin
            failures++;
            $display("FAIL latency_byte0: got req=%b byte=%h exp req=1 byte=d4", read_req, smi_data);
        end
        reg_read(5'd3, v);
        checks++;
        if (v !== 8'hC0) begin failures++; $display("FAIL ioc_state_shift: got %h exp c0", v); end
        model_run();
        collect(100);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL single_count: got %0d bytes exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_byte %0d: got ch%0d/%h exp ch%0d/%h", i, obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]);
            end
        end
        checks++;
        if ({pull_cnt[0] - p0, pull_cnt[1] - p1} !== {32'd1, 32'd0}) begin
            failures++; $display("FAIL single_pulls: got ch0=%0d ch1=%0d exp 1/0", pull_cnt[0] - p0, pull_cnt[1] - p1);
        end
    endtask

    task automatic test_burst();
        do_reset();
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            load_word(0, $urandom);
            load_word(1, $urandom);
        end
        model_run();
        collect(400);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL burst_count: got %0d bytes exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL burst_byte %0d: got ch%0d/%h exp ch%0d/%h", i, obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_mask_midword();
        logic [7:0] v;
        int p0;
        p0 = pull_cnt[0];
        obs_q.delete(); exp_q.delete();
        load_word(0, $urandom); load_word(0, $urandom);
        load_word(1, $urandom); load_word(1, $urandom);
        push_word(0, mq[0].pop_front());
        mask_m = 2'b10;
        last_m = 0;
        model_run();
        collect(1);
        reg_write(5'd2, 8'h02);
        collect(100);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL mask_count: got %0d bytes exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL mask_byte %0d: got ch%0d/%h exp ch%0d/%h", i, obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]);
            end
        end
        checks++;
        if (pull_cnt[0] - p0 !== 1) begin failures++; $display("FAIL mask_ch0_pulls: got %0d exp 1", pull_cnt[0] - p0); end
        reg_read(5'd2, v);
        checks++;
        if (v !== 8'h02) begin failures++; $display("FAIL mask_readback: got %h exp 02", v); end
        wr_ptr[0] = rd_ptr[0];
        mq[0].delete();
        reg_write(5'd2, 8'h03);
        mask_m = 2'b11;
    endtask

    task automatic test_reset_midword();
        obs_q.delete(); exp_q.delete();
        load_word(0, $urandom); load_word(0, $urandom);
        collect(2);
        rst = 1'b1;
        tick();
        checks++;
        if ({dout, pull, smi_data, read_req, active_ch} !== '0) begin
            failures++;
            $display("FAIL midword_reset: got dout=%h pull=%b smi=%h req=%b ch=%0d, all zero required",
                     dout, pull, smi_data, read_req, active_ch);
        end
        rst = 1'b0;
        void'(mq[0].pop_front());
        last_m = NUM_CH - 1;
        model_run();
        obs_q.delete();
        collect(100);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rst_count: got %0d bytes exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rst_byte %0d: got ch%0d/%h exp ch%0d/%h", i, obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]);
            end
        end
    endtask

    task automatic test_idle_strobes();
        int p0, p1;
        p0 = pull_cnt[0]; p1 = pull_cnt[1];
        for (int n = 0; n < 4; n++) begin
            strobe();
            checks++;
            if ({read_req, smi_data} !== 9'd0) begin
                failures++; $display("FAIL idle_strobe %0d: got req=%b byte=%h exp 0/00", n, read_req, smi_data);
            end
        end
        checks++;
        if ({pull_cnt[0] - p0, pull_cnt[1] - p1} !== 64'd0) begin
            failures++; $display("FAIL idle_pulls: got ch0=%0d ch1=%0d exp 0/0", pull_cnt[0] - p0, pull_cnt[1] - p1);
        end
        obs_q.delete(); exp_q.delete();
        load_word(1, $urandom);
        model_run();
        collect(100);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL idle_after_count: got %0d bytes exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL idle_after_byte %0d: got ch%0d/%h exp ch%0d/%h", i, obs_q[i][9:8], obs_q[i][7:0], exp_q[i][9:8], exp_q[i][7:0]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_burst();
        test_mask_midword();
        test_reset_midword();
        test_idle_strobes();
        checks++;
        if (underflow_cnt !== 0) begin failures++; $display("FAIL underflow: got %0d pulls on empty FIFOs exp 0", underflow_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
